// File: rtl/spi_accel_pkg.sv
// Shared types and constants for the SPI accelerometer controller: FSM states,
// device register map, power-up write table and the 16-bit command layout.
package spi_accel_pkg;

  typedef enum logic [2:0] {
    INIT_ISSUE, INIT_WAIT, IDLE, POLL_ISSUE, POLL_WAIT, HOST_ISSUE, HOST_WAIT
  } state_e;

  // Command word: [15]=read, [14]=multibyte (always 0), [13:8]=addr, [7:0]=wdata
  localparam int CMD_RD_BIT  = 15;
  localparam int CMD_MB_BIT  = 14;
  localparam int CMD_ADDR_HI = 13;
  localparam int CMD_ADDR_LO = 8;
  localparam int CMD_DATA_HI = 7;

  localparam logic [5:0] REG_BW_RATE     = 6'h2C;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;

  localparam int BURST_LEN    = 6;
  localparam int IDX_W        = 3;
  localparam int INIT_TBL_LEN = 3;

  // Entry 0 is issued first.
  localparam logic [INIT_TBL_LEN-1:0][5:0] INIT_ADDR = {REG_POWER_CTL, REG_BW_RATE, REG_DATA_FORMAT};
  localparam logic [INIT_TBL_LEN-1:0][7:0] INIT_DATA = {8'h08, 8'h0A, 8'h08};

  function automatic logic [15:0] mk_cmd(input logic rd, input logic [5:0] addr,
                                         input logic [7:0] wdata);
    logic [15:0] c;
    c = '0;
    c[CMD_RD_BIT] = rd;
    c[CMD_MB_BIT] = 1'b0;
    c[CMD_ADDR_HI:CMD_ADDR_LO] = addr;
    c[CMD_DATA_HI:0] = rd ? 8'h00 : wdata;
    return c;
  endfunction

  function automatic logic [15:0] init_cmd(input logic [IDX_W-1:0] i);
    logic [15:0] c;
    case (i)
      3'd0:    c = mk_cmd(1'b0, INIT_ADDR[0], INIT_DATA[0]);
      3'd1:    c = mk_cmd(1'b0, INIT_ADDR[1], INIT_DATA[1]);
      3'd2:    c = mk_cmd(1'b0, INIT_ADDR[2], INIT_DATA[2]);
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spi_poll_timer.sv
// Free-running poll divider: counts 0..POLL_DIV-1 while enabled and flags
// the wrap cycle with a single-cycle pulse.
module spi_poll_timer #(
  parameter int POLL_DIV = 2000
) (
  input  logic spi_clk,
  input  logic reset_n,
  input  logic en,
  output logic wrap
);

  localparam int CW = $clog2(POLL_DIV);

  logic [CW-1:0] cnt;

  assign wrap = en && (cnt == CW'(POLL_DIV - 1));

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (en)    cnt <= wrap ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/spi_accel_ctrl.sv
// Sequencer in front of an SPI serdes: writes the power-up table, polls the
// six accelerometer data registers on a timer and arbitrates host accesses.
module spi_accel_ctrl
  import spi_accel_pkg::*;
#(
  parameter int POLL_DIV = 2000,
  parameter int INIT_LEN = 3
) (
  input  logic        spi_clk,
  input  logic        reset_n,
  output logic        start,
  output logic [15:0] data_tx,
  input  logic        done,
  input  logic [7:0]  data_rx,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [5:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        data_valid,
  output logic        init_done,
  output logic        overrun
);

  localparam logic [IDX_W-1:0] INIT_LAST  = IDX_W'(INIT_LEN - 1);
  localparam logic [IDX_W-1:0] BURST_LAST = IDX_W'(BURST_LEN - 1);

  state_e                          state, next_state;
  logic [IDX_W-1:0]                idx;
  logic [15:0]                     cmd_q, issue_cmd;
  logic [BURST_LEN-2:0][7:0]       stage;
  logic                            poll_pending, wrap, is_issue;

  spi_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .spi_clk (spi_clk),
    .reset_n (reset_n),
    .en      (init_done),
    .wrap    (wrap)
  );

  assign is_issue = (state == INIT_ISSUE) || (state == POLL_ISSUE) || (state == HOST_ISSUE);

  always_comb begin
    issue_cmd = cmd_q;
    case (state)
      INIT_ISSUE: issue_cmd = init_cmd(idx);
      POLL_ISSUE: issue_cmd = mk_cmd(1'b1, REG_DATAX0 + 6'(idx), 8'h00);
      HOST_ISSUE: issue_cmd = mk_cmd(~host_wr, host_addr, host_wdata);
      default:    issue_cmd = cmd_q;
    endcase
  end

  // State register
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) state <= INIT_ISSUE;
    else          state <= next_state;
  end

  // Next-state; the ack cycle masks host_req so a held request is not re-taken
  always_comb begin
    next_state = state;
    case (state)
      INIT_ISSUE: next_state = INIT_WAIT;
      INIT_WAIT:  if (done) next_state = (idx == INIT_LAST) ? IDLE : INIT_ISSUE;
      IDLE: begin
        if (host_req && !host_ack) next_state = HOST_ISSUE;
        else if (poll_pending)     next_state = POLL_ISSUE;
      end
      POLL_ISSUE: next_state = POLL_WAIT;
      POLL_WAIT:  if (done) next_state = (idx == BURST_LAST) ? IDLE : POLL_ISSUE;
      HOST_ISSUE: next_state = HOST_WAIT;
      HOST_WAIT:  if (done) next_state = IDLE;
      default:    next_state = INIT_ISSUE;
    endcase
  end

  // Outputs; held low while in reset even though the state reads INIT_ISSUE
  always_comb begin
    start   = 1'b0;
    data_tx = cmd_q;
    if (!reset_n) begin
      data_tx = '0;
    end else if (is_issue) begin
      start   = 1'b1;
      data_tx = issue_cmd;
    end
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      cmd_q        <= '0;
      stage        <= '0;
      poll_pending <= 1'b0;
      overrun      <= 1'b0;
      init_done    <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      data_valid   <= 1'b0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
    end else begin
      host_ack   <= 1'b0;
      data_valid <= 1'b0;
      if (is_issue) cmd_q <= issue_cmd;

      if (done) begin
        case (state)
          INIT_WAIT: begin
            if (idx == INIT_LAST) begin
              init_done <= 1'b1;
              idx       <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          POLL_WAIT: begin
            if (idx == BURST_LAST) begin
              accel_x      <= {stage[1], stage[0]};
              accel_y      <= {stage[3], stage[2]};
              accel_z      <= {data_rx,  stage[4]};
              data_valid   <= 1'b1;
              poll_pending <= 1'b0;
              idx          <= '0;
            end else begin
              stage[idx] <= data_rx;
              idx        <= idx + 1'b1;
            end
          end
          HOST_WAIT: begin
            host_ack <= 1'b1;
            if (cmd_q[CMD_RD_BIT]) host_rdata <= data_rx;
          end
          default: ;
        endcase
      end

      // A tick landing on the burst's last done still counts as a new request
      if (wrap) begin
        poll_pending <= 1'b1;
        if (poll_pending) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_accel_ctrl.md
SPI_ACCEL_CTRL -- requirements
Module: spi_accel_ctrl

Interface
REQ-001 SHALL have parameter POLL_DIV, default 2000, spi_clk cycles between poll-burst starts (min 64).
REQ-002 SHALL have parameter INIT_LEN, default 3, number of init-table write transactions.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 spi_clk  in  1  clock; same clock as the serdes.
REQ-005 start  out  1  one-cycle transaction request to serdes.
REQ-006 data_tx  out  16  command: [15]=read, [14]=0 (no multibyte), [13:8]=register address, [7:0]=write data (0 on reads).
REQ-007 done  in  1  one-cycle transaction-complete pulse from serdes.
REQ-008 data_rx  in  8  read byte from serdes, valid when done=1.
REQ-009 host_req  in  1  host access request; level, held until host_ack.
REQ-010 host_wr  in  1  1=write, 0=read; sampled with host_req.
REQ-011 host_addr  in  6  host register address.
REQ-012 host_wdata  in  8  host write data.
REQ-013 host_ack  out  1  one-cycle pulse, host transaction complete.
REQ-014 host_rdata  out  8  read byte, valid from the host_ack cycle until the next host_ack.
REQ-015 accel_x/accel_y/accel_z  out  16 each  latest sample {high byte, low byte}.
REQ-016 data_valid  out  1  one-cycle pulse when accel_* update.
REQ-017 init_done  out  1  high once the init sequence completes; stays high.
REQ-018 overrun  out  1  sticky: a poll tick was lost.

Function
REQ-019 SHALL have states INIT_ISSUE, INIT_WAIT, IDLE, POLL_ISSUE, POLL_WAIT, HOST_ISSUE, HOST_WAIT.
REQ-020 Every ISSUE state SHALL last exactly one cycle with start=1 and data_tx valid, then go to the matching WAIT state; start=0 in all other states.
REQ-021 WAIT states SHALL hold data_tx stable and leave on the cycle after done=1; done seen in any other state SHALL be ignored.
REQ-022 Init table, in order: write 0x31<=0x08, write 0x2C<=0x0A, write 0x2D<=0x08; after the last done: init_done=1, go to IDLE.
REQ-023 The poll timer SHALL run only while init_done=1, counting 0..POLL_DIV-1 and wrapping; each wrap sets poll_pending.
REQ-024 If a wrap occurs while poll_pending=1, overrun SHALL be set; it clears only on reset.
REQ-025 Poll burst: six reads, addresses 0x32..0x37, back-to-back; each done captures data_rx into a staging byte.
REQ-026 On the final burst done: accel_x={b1,b0}, accel_y={b3,b2}, accel_z={b5,b4} all load on the same edge; data_valid pulses 1 cycle; poll_pending clears.
REQ-027 In IDLE, host_req=1 SHALL take priority over poll_pending=1 (same cycle included); a pending poll is kept, never dropped.
REQ-028 A burst SHALL NOT be interrupted; host_req during a burst or init waits until the next IDLE.
REQ-029 Host requests SHALL NOT be accepted before init_done=1.
REQ-030 Host transaction: data_tx={~host_wr,0,host_addr,host_wr?host_wdata:0}, latched at HOST_ISSUE; on done: host_ack=1, host_rdata=data_rx on reads, unchanged on writes.
REQ-031 Minimum spacing between done and the next start SHALL be 1 cycle (the ISSUE cycle follows the done cycle).

Reset
REQ-032 Reset asserted SHALL force INIT_ISSUE; start, host_ack, data_valid, init_done, overrun=0; data_tx, host_rdata, accel_*=0; timer and poll_pending=0.
REQ-033 Reset mid-transaction SHALL abort without waiting for done; after release, the init sequence restarts from entry 0.

Structure
REQ-034 Package spi_accel_pkg SHALL hold the state enum, register addresses (0x2C, 0x2D, 0x31, 0x32), the init table, and the command-field bit positions.
REQ-035 Sub-module spi_poll_timer SHALL implement the REQ-023 counter and the wrap pulse.

Verification
REQ-036 Reset release, serdes attached: three writes with data_tx=0x3108, 0x2C0A, 0x2D08 in order; then init_done=1.
REQ-037 POLL_DIV=64, model returns 0x10..0x15: data_valid pulses once; accel_x=0x1110, accel_y=0x1312, accel_z=0x1514.
REQ-038 host_req write addr 0x2E data 0x80: data_tx=0x2E80, one host_ack; host read of 0x00 with model 0xE5: data_tx=0x8000, host_rdata=0xE5.
REQ-039 host_req and the poll wrap in the same IDLE cycle: host transaction first, then the full six-read burst; no overrun.
REQ-040 host_req raised mid-burst: served only after data_valid; model stalls done longer than POLL_DIV: overrun=1.
REQ-041 reset_n pulsed during POLL_WAIT: outputs return to reset values; init restarts with data_tx=0x3108.
